// File: rtl/hs_math_basic_pkg.sv
// rtl/hs_math_basic_pkg.sv - small elaboration-time math helpers
package hs_math_basic_pkg;

    // Smallest power of two that is >= v (returns 1 for v <= 1).
    function automatic int ceil_to_nxt_pow2(input int v);
        int p;
        p = 1;
        while (p < v) p = p << 1;
        return p;
    endfunction

endpackage

// File: rtl/hs_mem_arb_pkg.sv
// rtl/hs_mem_arb_pkg.sv - shared types and round-robin pick function for the RAM arbiter
package hs_mem_arb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } hs_mem_arb_state_e;

    // Widest requester vector the pick function handles.
    localparam int RR_MAX = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] id;
    } rr_pick_t;

    // First set bit of valid[num-1:0], scanning cyclically upward from ptr.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [3:0]        ptr,
                                         input int unsigned       num);
        rr_pick_t    r;
        int unsigned idx;
        r = '0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            idx = (32'(ptr) + k) % num;
            if (k < num && !r.found && valid[idx[3:0]]) begin
                r.found = 1'b1;
                r.id    = idx[3:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hs_arb_rr.sv
// rtl/hs_arb_rr.sv - generic round-robin arbiter owning the rotating priority pointer
module hs_arb_rr
    import hs_mem_arb_pkg::*;
#(
    parameter int  NUM_REQ  = 4,
    localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                advance,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_WIDTH-1:0] gnt_id
);

    logic [ID_WIDTH-1:0] r_rr_ptr;
    rr_pick_t            w_pick;

    assign w_pick = rr_pick(RR_MAX'(req), 4'(r_rr_ptr), NUM_REQ);

    // Grant is purely combinational so ready can be returned in the request cycle.
    always_comb begin
        gnt    = (advance && w_pick.found) ? (NUM_REQ'(1) << w_pick.id) : '0;
        gnt_id = ID_WIDTH'(w_pick.id);
    end

    // Pointer moves just past the winner; idle cycles leave it in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (advance && w_pick.found) begin
            r_rr_ptr <= ID_WIDTH'((32'(w_pick.id) + 32'd1) % NUM_REQ);
        end
    end

endmodule

// File: rtl/hs_mem_spram.sv
// rtl/hs_mem_spram.sv - latency-1 read-first single-port RAM
module hs_mem_spram
    import hs_math_basic_pkg::*;
#(
    parameter type DATA_TYPE  = logic [7:0],
    parameter int  DATA_DEPTH = 16,
    localparam int ADDR_WIDTH = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  i_ce,
    input  logic                  i_wen,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  DATA_TYPE              i_wdata,
    output DATA_TYPE              o_rdata
);

    // Rounded up so every address the port can carry maps to storage.
    localparam int MEM_SIZE = ceil_to_nxt_pow2((DATA_DEPTH < 2) ? 2 : DATA_DEPTH);

    DATA_TYPE r_mem [MEM_SIZE];

    // Read-first access: old content is returned even when the same cycle writes.
    always_ff @(posedge clk) begin
        if (i_ce) begin
            o_rdata <= r_mem[i_addr];
            if (i_wen) r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/hs_mem_spram_arb.sv
// rtl/hs_mem_spram_arb.sv - round-robin sharing of one single-port RAM with zero-fill init
module hs_mem_spram_arb
    import hs_mem_arb_pkg::*;
#(
    parameter type DATA_TYPE  = logic [7:0],
    parameter int  DATA_DEPTH = 16,
    parameter int  NUM_REQ    = 4,
    parameter int  INIT_EN    = 1,
    localparam int ADDR_WIDTH = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
    localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  DATA_TYPE                            req_wdata [NUM_REQ],
    input  logic [NUM_REQ-1:0]                  req_wen,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output DATA_TYPE                            rsp_rdata,
    output logic                                init_done
);

    localparam hs_mem_arb_state_e RESET_STATE = (INIT_EN != 0) ? INIT : RUN;

    hs_mem_arb_state_e   r_state;
    hs_mem_arb_state_e   w_state_nxt;
    logic [ADDR_WIDTH:0] r_init_addr;
    logic                r_rsp_pend;
    logic [ID_WIDTH-1:0] r_rsp_id;

    logic                w_run;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [ID_WIDTH-1:0] w_gnt_id;
    logic                w_ram_wen;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    DATA_TYPE            w_ram_wdata;
    DATA_TYPE            w_ram_rdata;

    // State register; reset restarts the zero-fill when enabled.
    always_ff @(posedge clk) begin
        if (rst) r_state <= RESET_STATE;
        else     r_state <= w_state_nxt;
    end

    // Leave INIT right after the last address has been written.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == INIT && r_init_addr == (ADDR_WIDTH+1)'(DATA_DEPTH - 1)) begin
            w_state_nxt = RUN;
        end
    end

    // Init address walks one entry per cycle; the extra bit avoids wrap at power-of-2 depths.
    always_ff @(posedge clk) begin
        if (rst)                   r_init_addr <= '0;
        else if (r_state == INIT)  r_init_addr <= r_init_addr + 1'b1;
    end

    // Outputs and RAM port: zero-fill in INIT, granted requester in RUN; reset masks everything.
    always_comb begin
        w_run       = (r_state == RUN) && !rst;
        init_done   = w_run;
        req_ready   = w_gnt;
        w_ram_wen   = 1'b0;
        w_ram_addr  = '0;
        w_ram_wdata = '0;
        if (r_state == INIT) begin
            w_ram_wen  = 1'b1;
            w_ram_addr = r_init_addr[ADDR_WIDTH-1:0];
        end else begin
            w_ram_addr  = req_addr[w_gnt_id];
            w_ram_wdata = req_wdata[w_gnt_id];
            w_ram_wen   = (|w_gnt) && req_wen[w_gnt_id];
        end
    end

    // Remember who was served so the response pulse lands one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_pend <= 1'b0;
            r_rsp_id   <= '0;
        end else begin
            r_rsp_pend <= |w_gnt;
            r_rsp_id   <= w_gnt_id;
        end
    end

    assign rsp_valid = (r_rsp_pend && !rst) ? (NUM_REQ'(1) << r_rsp_id) : '0;
    assign rsp_rdata = w_ram_rdata;

    hs_arb_rr #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (w_run),
        .gnt     (w_gnt),
        .gnt_id  (w_gnt_id)
    );

    hs_mem_spram #(
        .DATA_TYPE  (DATA_TYPE),
        .DATA_DEPTH (DATA_DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_ce    (1'b1),
        .i_wen   (w_ram_wen),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_hs_mem_spram_arb.sv
// tb/tb_hs_mem_spram_arb.sv - self-checking bench for the shared single-port RAM arbiter
module tb_hs_mem_spram_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [3:0]       req_valid, req_ready, req_wen, rsp_valid;
    logic [3:0][3:0]  req_addr;
    logic [7:0]       req_wdata [4];
    logic [7:0]       rsp_rdata;
    logic             init_done;

    int checks = 0;
    int errors = 0;

    hs_mem_spram_arb #(
        .DATA_TYPE  (logic [7:0]),
        .DATA_DEPTH (16),
        .NUM_REQ    (4),
        .INIT_EN    (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wen   (req_wen),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
    );

    // Reference model state
    logic [7:0] m_mem [16];
    int         m_ptr = 0;
    bit         m_run = 0;
    int         m_cnt = 0;
    bit         m_pend = 0;
    int         m_id = 0;
    logic [7:0] m_dat = 8'h00;

    // Observed and expected values of the most recent cycle
    logic [3:0] o_rdy, e_rdy, o_rsp, e_rsp;
    logic [7:0] o_dat, e_dat;
    logic       o_done, e_done;

    // Requester stability monitor
    bit              mon_en = 0, p_en = 0;
    logic [3:0]      p_valid, p_ready, p_wen;
    logic [3:0][3:0] p_addr;
    logic [7:0]      p_wdata [4];

    always @(negedge clk) begin
        if (mon_en && p_en) begin
            for (int i = 0; i < 4; i++) begin
                if (p_valid[i] && !p_ready[i]) begin
                    checks++;
                    if (!req_valid[i] || req_addr[i] !== p_addr[i] || req_wen[i] !== p_wen[i] ||
                        req_wdata[i] !== p_wdata[i]) begin
                        errors++;
                        $display("FAIL hold_stable req%0d: valid=%b addr=%h wen=%b wdata=%h, required held addr=%h wen=%b wdata=%h",
                                 i, req_valid[i], req_addr[i], req_wen[i], req_wdata[i], p_addr[i], p_wen[i], p_wdata[i]);
                    end
                end
            end
        end
        p_en    = mon_en && !rst;
        p_valid = req_valid;
        p_ready = req_ready;
        p_wen   = req_wen;
        p_addr  = req_addr;
        for (int i = 0; i < 4; i++) p_wdata[i] = req_wdata[i];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_idle();
        req_valid = 4'h0;
        req_wen   = 4'h0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i]  = 4'h0;
            req_wdata[i] = 8'h00;
        end
    endtask

    // Samples the DUT for the current cycle, computes expectations from the model,
    // then advances the model and the clock. Called at posedge+1 with inputs applied.
    task automatic run_cycle();
        int g;
        int a;
        #1;
        o_rdy  = req_ready;
        o_rsp  = rsp_valid;
        o_dat  = rsp_rdata;
        o_done = init_done;
        g = -1;
        if (rst) begin
            e_rdy  = 4'h0;
            e_rsp  = 4'h0;
            e_done = 1'b0;
        end else begin
            e_rsp  = m_pend ? 4'(1 << m_id) : 4'h0;
            e_done = m_run;
            if (m_run) begin
                for (int k = 0; k < 4; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
            e_rdy = (g >= 0) ? 4'(1 << g) : 4'h0;
        end
        e_dat = m_dat;
        if (rst) begin
            m_run = 0; m_cnt = 0; m_ptr = 0; m_pend = 0;
        end else if (!m_run) begin
            m_mem[m_cnt] = 8'h00;
            if (m_cnt == 15) m_run = 1;
            m_cnt++;
            m_pend = 0;
        end else begin
            m_pend = (g >= 0);
            if (g >= 0) begin
                a     = int'(req_addr[g]);
                m_id  = g;
                m_dat = m_mem[a];
                if (req_wen[g]) m_mem[a] = req_wdata[g];
                m_ptr = (g + 1) % 4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        req_valid = 4'hF;
        repeat (3) begin
            run_cycle();
            checks++;
            if (o_rdy !== 4'h0) begin errors++; $display("FAIL reset_ready got %h want 0", o_rdy); end
            checks++;
            if (o_rsp !== 4'h0) begin errors++; $display("FAIL reset_rsp_valid got %h want 0", o_rsp); end
            checks++;
            if (o_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", o_done); end
        end
    endtask

    task automatic test_init_fill();
        rst = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) req_addr[i] = 4'(i);
        for (int c = 1; c <= 16; c++) begin
            run_cycle();
            checks++;
            if (o_done !== 1'b0) begin errors++; $display("FAIL init_done_early cycle %0d got %b want 0", c, o_done); end
            checks++;
            if (o_rdy !== 4'h0) begin errors++; $display("FAIL init_ready cycle %0d got %h want 0", c, o_rdy); end
        end
        req_valid = 4'h0;
        run_cycle();
        checks++;
        if (o_done !== 1'b1) begin errors++; $display("FAIL init_done_rise cycle 17 got %b want 1", o_done); end
    endtask

    task automatic test_fairness();
        req_valid = 4'hF;
        req_wen   = 4'h0;
        for (int i = 0; i < 4; i++) req_addr[i] = 4'($urandom_range(0, 15));
        for (int k = 0; k < 8; k++) begin
            run_cycle();
            checks++;
            if (o_rdy !== 4'(1 << (k % 4)))
                begin errors++; $display("FAIL rr_order grant %0d got %h want %h", k, o_rdy, 4'(1 << (k % 4))); end
            checks++;
            if (o_rsp !== ((k == 0) ? 4'h0 : 4'(1 << ((k - 1) % 4))))
                begin errors++; $display("FAIL rr_rsp cycle %0d got %h", k, o_rsp); end
            if (k > 0) begin
                checks++;
                if (o_dat !== e_dat) begin errors++; $display("FAIL rr_rdata cycle %0d got %h want %h", k, o_dat, e_dat); end
            end
        end
        set_idle();
        run_cycle();
        checks++;
        if (o_rsp !== 4'h8) begin errors++; $display("FAIL rr_last_rsp got %h want 8", o_rsp); end
    endtask

    task automatic test_read_first();
        set_idle();
        req_valid[2] = 1'b1; req_wen[2] = 1'b1; req_addr[2] = 4'd3; req_wdata[2] = 8'hA5;
        run_cycle();
        checks++;
        if (o_rdy !== 4'h4) begin errors++; $display("FAIL rf_write_grant got %h want 4", o_rdy); end
        set_idle();
        req_valid[1] = 1'b1; req_addr[1] = 4'd3;
        run_cycle();
        checks++;
        if (o_rdy !== 4'h2) begin errors++; $display("FAIL rf_read_grant got %h want 2", o_rdy); end
        checks++;
        if (o_rsp !== 4'h4 || o_dat !== 8'h00)
            begin errors++; $display("FAIL rf_write_rsp got valid %h data %h want valid 4 data 00", o_rsp, o_dat); end
        set_idle();
        run_cycle();
        checks++;
        if (o_rsp !== 4'h2 || o_dat !== 8'hA5)
            begin errors++; $display("FAIL rf_read_rsp got valid %h data %h want valid 2 data a5", o_rsp, o_dat); end
    endtask

    task automatic test_sparse();
        set_idle();
        req_valid[1] = 1'b1;
        run_cycle();
        checks++;
        if (o_rdy !== 4'h2) begin errors++; $display("FAIL sparse_req1 got %h want 2", o_rdy); end
        set_idle();
        req_valid[3] = 1'b1;
        run_cycle();
        checks++;
        if (o_rdy !== 4'h8) begin errors++; $display("FAIL sparse_req3 got %h want 8", o_rdy); end
        set_idle();
        for (int c = 0; c < 3; c++) begin
            run_cycle();
            checks++;
            if (o_rsp !== ((c == 0) ? 4'h8 : 4'h0)) begin errors++; $display("FAIL sparse_idle_rsp %0d got %h", c, o_rsp); end
            checks++;
            if (o_rdy !== 4'h0) begin errors++; $display("FAIL sparse_idle_ready %0d got %h want 0", c, o_rdy); end
        end
        req_valid = 4'b1001;
        run_cycle();
        checks++;
        if (o_rdy !== 4'h1) begin errors++; $display("FAIL sparse_ptr_wrap got %h want 1", o_rdy); end
        set_idle();
        run_cycle();
        checks++;
        if (o_rsp !== 4'h1) begin errors++; $display("FAIL sparse_wrap_rsp got %h want 1", o_rsp); end
    endtask

    task automatic test_soak();
        mon_en = 1;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!(req_valid[i] && !o_rdy[i])) begin
                    req_valid[i] = ($urandom_range(0, 99) < 60);
                    req_wen[i]   = $urandom_range(0, 1);
                    req_addr[i]  = 4'($urandom_range(0, 15));
                    req_wdata[i] = 8'($urandom);
                end
            end
            run_cycle();
            checks++;
            if (o_rdy !== e_rdy) begin errors++; $display("FAIL soak_ready cycle %0d got %h want %h", n, o_rdy, e_rdy); end
            checks++;
            if (o_rsp !== e_rsp) begin errors++; $display("FAIL soak_rsp cycle %0d got %h want %h", n, o_rsp, e_rsp); end
            if (e_rsp != 4'h0) begin
                checks++;
                if (o_dat !== e_dat) begin errors++; $display("FAIL soak_rdata cycle %0d got %h want %h", n, o_dat, e_dat); end
            end
        end
        mon_en = 0;
    endtask

    task automatic test_reset_mid();
        set_idle();
        run_cycle();
        req_valid[0] = 1'b1; req_addr[0] = 4'd5;
        run_cycle();
        checks++;
        if (o_rdy !== 4'h1) begin errors++; $display("FAIL mid_accept got %h want 1", o_rdy); end
        rst = 1'b1;
        set_idle();
        repeat (2) begin
            run_cycle();
            checks++;
            if (o_rsp !== 4'h0) begin errors++; $display("FAIL mid_rsp_dropped got %h want 0", o_rsp); end
        end
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            run_cycle();
            checks++;
            if (o_rsp !== 4'h0 || o_done !== 1'b0)
                begin errors++; $display("FAIL mid_reinit cycle %0d got rsp %h done %b want 0 0", c, o_rsp, o_done); end
        end
        req_valid = 4'hF;
        run_cycle();
        checks++;
        if (o_done !== 1'b1 || o_rdy !== 4'h1)
            begin errors++; $display("FAIL mid_first_grant got done %b ready %h want 1 1", o_done, o_rdy); end
        for (int a = 1; a <= 16; a++) begin
            set_idle();
            if (a < 16) begin req_valid[0] = 1'b1; req_addr[0] = 4'(a); end
            run_cycle();
            checks++;
            if (o_rsp !== 4'h1 || o_dat !== 8'h00)
                begin errors++; $display("FAIL zero_fill addr %0d got valid %h data %h want 1 00", a - 1, o_rsp, o_dat); end
        end
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        o_rdy = 4'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_init_fill();
        test_fairness();
        test_read_first();
        test_sparse();
        test_soak();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
